mdu_unit: RTL
=============

Name: mdu_unit

Overview:
Multi-cycle multiply/divide unit for the pipelined MIPS core. It is the parametrised successor to the combinational EX-stage ALU and sits beside it in EX. It executes mult/multu/div/divu with configurable latency and owns the HI/LO registers for mthi/mtlo/mfhi/mflo. It exposes a busy flag that the hazard unit uses to stall md-class instructions.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (even, >= 8)
MULT_CYCLES, 5, cycles busy is high for mult/multu (>= 1)
DIV_CYCLES, 10, cycles busy is high for div/divu (>= 1)

Ports:
clk  input  1  core clock, rising-edge
reset_n  input  1  asynchronous active-low reset
start  input  1  issue strobe from EX for the operation on mdu_op
mdu_op  input  3  operation code (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO)
A  input  WIDTH  rs operand
B  input  WIDTH  rt operand
busy  output  1  multi-cycle operation in flight
hi  output  WIDTH  HI register, for mfhi
lo  output  WIDTH  LO register, for mflo

Behaviour:
- Reset (reset_n=0, asynchronous, any time including mid-operation): hi=0, lo=0, busy=0, state=IDLE, counter=0, pending results cleared. Any in-flight operation is discarded.
- States:
  - IDLE -> MUL on start with MULT/MULTU
  - IDLE -> DIV on start with DIV/DIVU
  - MUL/DIV -> IDLE when the counter reaches 1 at a rising edge
- busy = (state != IDLE). It is a registered state decode with no combinational path from start.
- Accept: start is sampled at rising edge E0 only when busy=0. At E0 the result is computed from A/B and latched into pending_hi/pending_lo, and the counter is loaded with N (MULT_CYCLES or DIV_CYCLES).
- start while busy=1 is ignored, and HI/LO are not disturbed. The hazard unit guarantees this does not happen; the verification bench must still check it.
- Latency: busy is 1 for exactly N cycles after E0. At edge E_N, hi/lo take the pending values and busy falls at that same edge. The counter decrements once per cycle while busy.
- MTHI/MTLO with start=1 and busy=0: hi (respectively lo) <= A at that edge. These take one cycle, never raise busy, and do not touch the other register.
- MTHI/MTLO while busy: ignored.
- mfhi/mflo read hi/lo combinationally. Values are stale until E_N, so the stall must cover busy|start.
- Arithmetic:
  - MULT: signed WIDTH x WIDTH -> 2*WIDTH product; hi = upper WIDTH bits, lo = lower WIDTH bits.
  - MULTU: same split, with an unsigned product.
  - DIV: signed; lo = quotient truncated toward zero; hi = remainder, which carries the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (DIV/DIVU with B=0): lo = all ones, hi = A. Full latency still applies.
- Signed overflow (DIV with A = -2^(WIDTH-1), B = -1): lo = A, hi = 0, with no trap.
- Undefined mdu_op with start=1: no-op, busy stays 0.
- A/B changing after E0 must not affect the result.

Decomposition:
- Shared package/header (def.v style): MDU_* op encodings (3-bit) and state encodings (IDLE, MUL, DIV).
- One natural sub-module: mdu_calc. It is combinational: it takes op, A and B and produces the {hi, lo} pair, including the div-by-zero and overflow rules.
- The top level keeps the FSM, counter, pending registers and HI/LO.

Test Plan:
- Multiply latency:
  - Stimulus: reset, then start MULT with A=0xFFFF_FFFE (-2) and B=3.
  - Response: busy=1 for exactly 5 cycles; at E_5, hi=0xFFFF_FFFF and lo=0xFFFF_FFFA.
- MULTU:
  - Stimulus: A=0xFFFF_FFFF, B=2.
  - Response: hi=0x0000_0001, lo=0xFFFF_FFFE after 5 cycles.
- DIV signed:
  - Stimulus: DIV with A=-7 (0xFFFF_FFF9), B=2.
  - Response: after 10 busy cycles, lo=0xFFFF_FFFD (-3) and hi=0xFFFF_FFFF (-1).
  - Stimulus: DIVU with A=7, B=2.
  - Response: lo=3, hi=1.
- Division boundaries:
  - Stimulus: DIV with A=5, B=0.
  - Response: lo=0xFFFF_FFFF, hi=5.
  - Stimulus: DIV with A=0x8000_0000, B=0xFFFF_FFFF.
  - Response: lo=0x8000_0000, hi=0.
- Move and ignore rules:
  - Stimulus: MTHI A=0x1234 at an idle edge.
  - Response: hi=0x1234 next cycle, lo unchanged, busy stays 0.
  - Stimulus: start MULT, then assert start with MTLO and with DIV mid-busy.
  - Response: both ignored; the final hi/lo equal the MULT result.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 asynchronously 3 cycles into a DIV.
  - Response: busy, hi and lo are 0 immediately, without waiting for a clock edge; after release no commit ever occurs; a new MULT issued afterwards completes normally.

Source files
------------

// File: rtl/mdu_unit_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
package mdu_unit_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  // True for ops that occupy the unit for multiple cycles.
  function automatic logic is_md_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_unit_calc.sv
// Combinational arithmetic core: produces the {hi, lo} pair for mult/multu/div/divu,
// including the divide-by-zero and signed-overflow results.
module mdu_calc
  import mdu_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] ext_a;
  logic signed [2*WIDTH-1:0] ext_b;
  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic                      div_zero;
  logic                      div_ovf;
  logic signed [WIDTH-1:0]   sa;
  logic signed [WIDTH-1:0]   sb;
  logic signed [WIDTH-1:0]   quot_s;
  logic signed [WIDTH-1:0]   rem_s;
  logic        [WIDTH-1:0]   safe_b;
  logic        [WIDTH-1:0]   quot_u;
  logic        [WIDTH-1:0]   rem_u;

  // Divide-by-zero: quotient all ones, remainder is the dividend.
  function automatic logic [2*WIDTH-1:0] div_by_zero_result(input logic [WIDTH-1:0] dividend);
    return {dividend, {WIDTH{1'b1}}};
  endfunction

  // Signed overflow (most negative / -1): quotient wraps to the dividend, remainder zero.
  function automatic logic [2*WIDTH-1:0] div_overflow_result(input logic [WIDTH-1:0] dividend);
    return {{WIDTH{1'b0}}, dividend};
  endfunction

  // Products, quotients and remainders for every op, selected by op.
  always_comb begin
    ext_a    = signed'({{WIDTH{a[WIDTH-1]}}, a});
    ext_b    = signed'({{WIDTH{b[WIDTH-1]}}, b});
    prod_s   = ext_a * ext_b;
    prod_u   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    div_zero = (b == '0);
    div_ovf  = (a == MOST_NEG) && (b == '1);
    // The divider never sees the special-case operands, so no x/trap can arise.
    safe_b   = (div_zero || div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
    sa       = signed'(a);
    sb       = signed'(safe_b);
    quot_s   = sa / sb;
    rem_s    = sa % sb;
    quot_u   = a / safe_b;
    rem_u    = a % safe_b;
    hi       = '0;
    lo       = '0;
    case (op)
      MDU_MULT:  {hi, lo} = prod_s;
      MDU_MULTU: {hi, lo} = prod_u;
      MDU_DIV: begin
        if (div_zero)     {hi, lo} = div_by_zero_result(a);
        else if (div_ovf) {hi, lo} = div_overflow_result(a);
        else              {hi, lo} = {rem_s, quot_s};
      end
      MDU_DIVU: begin
        if (div_zero) {hi, lo} = div_by_zero_result(a);
        else          {hi, lo} = {rem_u, quot_u};
      end
      default: {hi, lo} = '0;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at issue,
// held in pending registers, and committed to HI/LO when the latency counter expires.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       mdu_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MUL_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] pending_hi;
  logic [WIDTH-1:0] pending_lo;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] calc_hi;
  logic [WIDTH-1:0] calc_lo;

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op (mdu_op),
    .a  (A),
    .b  (B),
    .hi (calc_hi),
    .lo (calc_lo)
  );

  assign busy = (state != ST_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // FSM: accept ops only when idle, count down the latency, commit pending results at expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      count      <= '0;
      pending_hi <= '0;
      pending_lo <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_md_op(mdu_op)) begin
              pending_hi <= calc_hi;
              pending_lo <= calc_lo;
              if ((mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU)) begin
                state <= ST_MUL;
                count <= MUL_N;
              end else begin
                state <= ST_DIV;
                count <= DIV_N;
              end
            end else if (mdu_op == MDU_MTHI) begin
              hi_q <= A;
            end else if (mdu_op == MDU_MTLO) begin
              lo_q <= A;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (count == ONE) begin
            state <= ST_IDLE;
            count <= '0;
            hi_q  <= pending_hi;
            lo_q  <= pending_lo;
          end else begin
            count <= count - ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule
